// File: rtl/unified_mem_ctrl_pkg.sv
// Shared definitions for the unified memory controller: FSM states, port IDs
// and the byte-to-word address offset.
package unified_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } memStateT;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } portIdT;

  localparam int WORD_LSB = 2;

  function automatic portIdT otherPort(portIdT p);
    return (p == INSTR) ? DATA : INSTR;
  endfunction

endpackage

// File: rtl/unified_mem_ctrl_if.sv
// Core-side bus of the unified memory: fetch port, load/store port and stall.
interface unified_mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_valid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              stall;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_rdata, i_valid, d_rdata, d_valid, stall
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_rdata, i_valid, d_rdata, d_valid, stall
  );
endinterface

// File: rtl/unified_mem_ctrl_array.sv
// Shared word array: synchronous write, combinational read, contents never reset.
module mem_word_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wd,
  output logic [DATA_W-1:0]        rd
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wd;
  end

  always_comb rd = mem[idx];
endmodule

// File: rtl/unified_mem_ctrl.sv
// Unified instruction/data memory: round-robin arbitration between fetch and
// load/store ports, fixed wait states per access, and a core stall output.
module unified_mem_ctrl
  import unified_mem_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  unified_mem_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  memStateT          state, nextState;
  portIdT            grantPort, lastGrant, reqPort;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addrReg;
  logic              weReg;
  logic [DATA_W-1:0] wdataReg;
  logic [DATA_W-1:0] iRdata, dRdata;
  logic              anyReq, grantNow, inRange, commitNow;
  logic              iValid, dValid;
  logic [IDX_W-1:0]  arrIdx;
  logic [DATA_W-1:0] arrRd, readWord;
  logic              arrWe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = ACCESS;
      ACCESS:  if (cnt == '0) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    iValid      = (state == DONE) && (grantPort == INSTR);
    dValid      = (state == DONE) && (grantPort == DATA);
    bus.i_valid = iValid;
    bus.d_valid = dValid;
    bus.i_rdata = iRdata;
    bus.d_rdata = dRdata;
    bus.stall   = (bus.i_req & ~iValid) | (bus.d_req & ~dValid);
  end

  // Contention goes to whichever port was not served last; lastGrant resets
  // to INSTR so DATA wins the first tie.
  always_comb begin
    anyReq   = bus.i_req | bus.d_req;
    grantNow = (state == IDLE) && anyReq;
    if (bus.i_req && bus.d_req) reqPort = otherPort(lastGrant);
    else if (bus.d_req)         reqPort = DATA;
    else                        reqPort = INSTR;
  end

  always_comb begin
    arrIdx    = addrReg[IDX_W+WORD_LSB-1:WORD_LSB];
    inRange   = (addrReg >> (IDX_W + WORD_LSB)) == '0;
    commitNow = (state == ACCESS) && (cnt == '0);
    arrWe     = commitNow && weReg && inRange;
    readWord  = inRange ? arrRd : '0;
  end

  mem_word_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) uArray (
    .clk (clk),
    .we  (arrWe),
    .idx (arrIdx),
    .wd  (wdataReg),
    .rd  (arrRd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grantPort <= INSTR;
      lastGrant <= INSTR;
      cnt       <= '0;
      addrReg   <= '0;
      weReg     <= 1'b0;
      wdataReg  <= '0;
      iRdata    <= '0;
      dRdata    <= '0;
    end else if (grantNow) begin
      grantPort <= reqPort;
      addrReg   <= (reqPort == DATA) ? bus.d_addr : bus.i_addr;
      weReg     <= (reqPort == DATA) && bus.d_we;
      wdataReg  <= bus.d_wdata;
      cnt       <= 4'(WAIT_CYCLES);
    end else if (state == ACCESS) begin
      if (cnt != '0) begin
        cnt <= cnt - 4'd1;
      end else begin
        lastGrant <= grantPort;
        if (!weReg) begin
          if (grantPort == DATA) dRdata <= readWord;
          else                   iRdata <= readWord;
        end
      end
    end
  end
endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed bench for unified_mem_ctrl: vector table of single transactions on a
// WAIT_CYCLES=2 instance plus reset/arbitration sequences and a WAIT_CYCLES=0 instance.
module tb_unified_mem_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nTests = 0;
  int   nFail = 0;
  logic [31:0] lastD = '0;

  always #5 clk = ~clk;

  unified_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
  unified_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

  unified_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );
  unified_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  typedef struct {
    logic        isData;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vecT;

  vecT vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic runVec(input int k, input vecT v);
    int   n;
    logic got;
    @(posedge clk); #1;
    if (v.isData) begin
      bus2.d_req = 1'b1; bus2.d_we = v.we; bus2.d_addr = v.addr; bus2.d_wdata = v.wdata;
    end else begin
      bus2.i_req = 1'b1; bus2.i_addr = v.addr;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      got = v.isData ? bus2.d_valid : bus2.i_valid;
    end
    check($sformatf("vec%0d latency", k), 32'(n), 32'd4);
    if (got) begin
      if (v.isData && v.we) begin
        check($sformatf("vec%0d store d_rdata held", k), bus2.d_rdata, lastD);
      end else if (v.isData) begin
        check($sformatf("vec%0d d_rdata", k), bus2.d_rdata, v.exp);
        lastD = v.exp;
      end else begin
        check($sformatf("vec%0d i_rdata", k), bus2.i_rdata, v.exp);
        check($sformatf("vec%0d d_rdata held", k), bus2.d_rdata, lastD);
      end
      check($sformatf("vec%0d other valid", k), 32'(v.isData ? bus2.i_valid : bus2.d_valid), 32'd0);
      check($sformatf("vec%0d stall at valid", k), 32'(bus2.stall), 32'd0);
    end
    bus2.d_req = 1'b0; bus2.i_req = 1'b0; bus2.d_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h8888_8888, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0000, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0BAD_F00D};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0013, 32'hCAFE_F00D, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_0012, 32'h0,         32'hCAFE_F00D};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_00FC, 32'h55AA_55AA, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0,         32'h55AA_55AA};
    vecs[13] = '{1'b1, 1'b1, 32'h8000_0000, 32'h7777_7777, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0BAD_F00D};
    vecs[15] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         32'h0};

    bus2.i_req = 1'b0; bus2.i_addr = '0; bus2.d_req = 1'b0;
    bus2.d_we = 1'b0; bus2.d_addr = '0; bus2.d_wdata = '0;
    bus0.i_req = 1'b0; bus0.i_addr = '0; bus0.d_req = 1'b0;
    bus0.d_we = 1'b0; bus0.d_addr = '0; bus0.d_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("por d_valid", 32'(bus2.d_valid), 32'd0);
    check("por d_rdata", bus2.d_rdata, 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 16; k++) runVec(k, vecs[k]);

    // Reset with both requests held, then simultaneous fetch and load.
    @(posedge clk); #1;
    reset = 1'b1;
    bus2.i_req = 1'b1; bus2.i_addr = 32'h0;
    bus2.d_req = 1'b1; bus2.d_we = 1'b0; bus2.d_addr = 32'h8;
    repeat (3) @(posedge clk);
    #1;
    check("rst i_valid", 32'(bus2.i_valid), 32'd0);
    check("rst d_valid", 32'(bus2.d_valid), 32'd0);
    check("rst i_rdata", bus2.i_rdata, 32'd0);
    check("rst d_rdata", bus2.d_rdata, 32'd0);
    check("rst stall", 32'(bus2.stall), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    lastD = '0;
    for (int n = 0; n < 12; n++) begin
      check($sformatf("arb d_valid c%0d", n), 32'(bus2.d_valid), 32'(n == 4));
      check($sformatf("arb i_valid c%0d", n), 32'(bus2.i_valid), 32'(n == 9));
      check($sformatf("arb stall c%0d", n), 32'(bus2.stall), 32'(n < 9));
      if (n == 4) begin
        check("arb d_rdata", bus2.d_rdata, 32'h8888_8888);
        lastD = 32'h8888_8888;
        bus2.d_req = 1'b0;
      end
      if (n == 9) begin
        check("arb i_rdata", bus2.i_rdata, 32'h0BAD_F00D);
        bus2.i_req = 1'b0;
      end
      @(posedge clk); #1;
    end

    // Reset while a store sits in ACCESS with cnt = 1: the write must be lost.
    bus2.d_req = 1'b1; bus2.d_we = 1'b1; bus2.d_addr = 32'h20; bus2.d_wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    bus2.d_req = 1'b0; bus2.d_we = 1'b0;
    @(posedge clk); #1;
    check("abort d_valid", 32'(bus2.d_valid), 32'd0);
    check("abort d_rdata", bus2.d_rdata, 32'd0);
    reset = 1'b0;
    lastD = '0;
    runVec(16, '{1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h0});

    // Zero wait states, both ports requesting continuously.
    @(posedge clk); #1;
    bus0.i_req = 1'b1; bus0.i_addr = 32'h4;
    bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 32'hC;
    for (int n = 0; n < 18; n++) begin
      check($sformatf("w0 d_valid c%0d", n), 32'(bus0.d_valid), 32'((n % 6) == 2));
      check($sformatf("w0 i_valid c%0d", n), 32'(bus0.i_valid), 32'((n % 6) == 5));
      @(posedge clk); #1;
    end
    bus0.i_req = 1'b0; bus0.d_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
